// File: rtl/func_sweep_pkg.sv
// Shared types and default sizing for the truth-table sweep controller.
// The wait-counter width helper keeps at least one bit when LAT is zero.
package func_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int DEF_N_IN  = 6;
    localparam int DEF_TT_W  = 1 << DEF_N_IN;
    localparam int DEF_CNT_W = DEF_N_IN + 1;
    localparam int DEF_LAT   = 0;

    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    localparam int DEF_LAT_W = lat_cnt_w(DEF_LAT);

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Request/result bundle between a sweep requester and func_sweep_ctrl,
// plus the two wires that reach the function under test.
import func_sweep_pkg::*;

interface func_sweep_ctrl_if #(parameter int N_IN = DEF_N_IN);

    localparam int TT_W = 1 << N_IN;

    logic              start;
    logic [TT_W-1:0]   expect_tt;
    logic [N_IN-1:0]   func_x;
    logic              func_y;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_bad;
    logic              any_bad;

    modport master (
        output start, expect_tt, func_y,
        input  func_x, busy, done, tt, mismatch_cnt, first_bad, any_bad
    );

    modport slave (
        input  start, expect_tt, func_y,
        output func_x, busy, done, tt, mismatch_cnt, first_bad, any_bad
    );

endinterface

// File: rtl/func_sweep_ctrl_sweep_counter.sv
// Vector/wait counter: holds each vector for LAT+1 cycles and flags the
// sampling cycle. vec wraps to zero after the last vector so func_x idles at 0.
import func_sweep_pkg::*;

module sweep_counter #(
    parameter int N_IN = DEF_N_IN,
    parameter int LAT  = DEF_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            run_i,
    output logic [N_IN-1:0] vec_o,
    output logic            sample_now_o,
    output logic            last_vec_o
);

    localparam int LAT_W = lat_cnt_w(LAT);

    logic [N_IN-1:0]  vec_q, vec_d;
    logic [LAT_W-1:0] wait_q, wait_d;

    assign sample_now_o = run_i && (wait_q == LAT_W'(LAT));
    assign last_vec_o   = (vec_q == {N_IN{1'b1}});
    assign vec_o        = vec_q;

    // Next vector/wait value: clear on accept, advance only while evaluating.
    always_comb begin
        vec_d  = vec_q;
        wait_d = wait_q;
        if (clear_i) begin
            vec_d  = '0;
            wait_d = '0;
        end else if (sample_now_o) begin
            vec_d  = vec_q + N_IN'(1);
            wait_d = '0;
        end else if (run_i) begin
            wait_d = wait_q + LAT_W'(1);
        end else begin
            vec_d  = vec_q;
            wait_d = wait_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            wait_q <= '0;
        end else begin
            vec_q  <= vec_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/func_sweep_ctrl.sv
// Sweeps all 2^N_IN input vectors through an external function, captures the
// observed truth table and scores it against the expected one.
import func_sweep_pkg::*;

module func_sweep_ctrl #(
    parameter int N_IN = DEF_N_IN,
    parameter int LAT  = DEF_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    func_sweep_ctrl_if.slave sw
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = N_IN + 1;

    state_e            state_q, state_d;
    logic              accept_s, run_s, sample_now_s, last_vec_s;
    logic [N_IN-1:0]   vec_s;
    logic              busy_q, busy_d, done_q, done_d;
    logic [TT_W-1:0]   exp_q, exp_d, tt_q, tt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              any_q, any_d;

    // A start is taken whenever no sweep is running, including in FIN.
    assign accept_s = sw.start && (state_q != EVAL);
    assign run_s    = (state_q == EVAL);

    sweep_counter #(.N_IN(N_IN), .LAT(LAT)) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (accept_s),
        .run_i        (run_s),
        .vec_o        (vec_s),
        .sample_now_o (sample_now_s),
        .last_vec_o   (last_vec_s)
    );

    // Next-state and registered status decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_s) state_d = EVAL; else state_d = IDLE;
            EVAL:    if (sample_now_s && last_vec_s) state_d = FIN; else state_d = EVAL;
            FIN:     if (accept_s) state_d = EVAL; else state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == EVAL);
        done_d = (state_d == FIN);
    end

    // Capture and compare: only the last cycle of each vector window counts.
    always_comb begin
        exp_d   = exp_q;
        tt_d    = tt_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        any_d   = any_q;
        if (accept_s) begin
            exp_d   = sw.expect_tt;
            tt_d    = '0;
            cnt_d   = '0;
            first_d = '0;
            any_d   = 1'b0;
        end else if (sample_now_s) begin
            tt_d[vec_s] = sw.func_y;
            if (sw.func_y != exp_q[vec_s]) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!any_q) begin
                    first_d = vec_s;
                    any_d   = 1'b1;
                end else begin
                    first_d = first_q;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            tt_d = tt_q;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exp_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            any_q   <= any_d;
        end
    end

    assign sw.func_x       = vec_s;
    assign sw.busy         = busy_q;
    assign sw.done         = done_q;
    assign sw.tt           = tt_q;
    assign sw.mismatch_cnt = cnt_q;
    assign sw.first_bad    = first_q;
    assign sw.any_bad      = any_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: a combinational instance (LAT=0) and a
// two-register-delayed instance (LAT=2) swept against a table-driven fixture.
module tb_func_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] fn_tt = 64'd0;
    logic        d1 = 1'b0;
    logic        d2 = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [5:0]  xlog [0:255];
    int          xcount = 0;
    int          overlap = 0;

    func_sweep_ctrl_if #(.N_IN(6)) if0 ();
    func_sweep_ctrl_if #(.N_IN(6)) if2 ();

    func_sweep_ctrl #(.N_IN(6), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .sw(if0.slave));
    func_sweep_ctrl #(.N_IN(6), .LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .sw(if2.slave));

    always #5 clk = ~clk;

    assign if0.func_y = fn_tt[if0.func_x];
    always @(posedge clk) begin
        d1 <= fn_tt[if2.func_x];
        d2 <= d1;
    end
    assign if2.func_y = d2;

    function automatic int popc(input logic [63:0] v);
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [63:0] parity_tt();
        logic [63:0] t = 64'd0;
        for (int i = 0; i < 64; i++) t[i] = ^(6'(i));
        return t;
    endfunction

    // Launch one sweep, log func_x for every busy cycle, return the cycle of done.
    task automatic run_sweep(input bit use2, input logic [63:0] exp, input int pulse_k,
                             output int done_k);
        logic b, d;
        logic [5:0] x;
        xcount = 0; overlap = 0; done_k = -1;
        if (use2) begin if2.start = 1'b1; if2.expect_tt = exp; end
        else begin if0.start = 1'b1; if0.expect_tt = exp; end
        @(negedge clk);
        for (int k = 1; k <= 300; k++) begin
            if0.start = 1'b0; if2.start = 1'b0;
            if (k == pulse_k) begin
                if (use2) begin if2.start = 1'b1; if2.expect_tt = ~exp; end
                else begin if0.start = 1'b1; if0.expect_tt = ~exp; end
            end
            b = use2 ? if2.busy : if0.busy;
            d = use2 ? if2.done : if0.done;
            x = use2 ? if2.func_x : if0.func_x;
            if (b && d) overlap++;
            if (d) begin done_k = k; break; end
            if (xcount < 256) begin xlog[xcount] = x; xcount++; end
            @(negedge clk);
        end
        if0.start = 1'b0; if2.start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (if0.func_x !== 6'd0) begin n_bad++; $display("FAIL reset_func_x got %0d want 0", if0.func_x); end
        n_cmp++; if (if0.busy !== 1'b0 || if2.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b/%b want 0", if0.busy, if2.busy); end
        n_cmp++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", if0.done); end
        n_cmp++; if (if0.tt !== 64'd0) begin n_bad++; $display("FAIL reset_tt got %h want 0", if0.tt); end
        n_cmp++; if (if0.mismatch_cnt !== 7'd0 || if0.first_bad !== 6'd0 || if0.any_bad !== 1'b0) begin
            n_bad++; $display("FAIL reset_results got %0d/%0d/%b want 0/0/0", if0.mismatch_cnt, if0.first_bad, if0.any_bad); end
    endtask

    task automatic test_parity();
        int dk, errs;
        fn_tt = parity_tt();
        run_sweep(1'b0, 64'h6996_9669_9669_6996, -1, dk);
        n_cmp++; if (dk !== 65) begin n_bad++; $display("FAIL parity_done_cycle got %0d want 65", dk); end
        n_cmp++; if (if0.tt !== 64'h6996_9669_9669_6996) begin n_bad++; $display("FAIL parity_tt got %h want 6996966996696996", if0.tt); end
        n_cmp++; if (if0.mismatch_cnt !== 7'd0 || if0.any_bad !== 1'b0 || if0.first_bad !== 6'd0) begin
            n_bad++; $display("FAIL parity_results got %0d/%b/%0d want 0/0/0", if0.mismatch_cnt, if0.any_bad, if0.first_bad); end
        errs = 0;
        for (int i = 0; i < xcount; i++) if (xlog[i] !== 6'(i)) errs++;
        n_cmp++; if (errs != 0 || xcount != 64 || overlap != 0) begin
            n_bad++; $display("FAIL parity_func_x_seq got %0d bad of %0d overlap %0d want 0 of 64", errs, xcount, overlap); end
        @(negedge clk);
        n_cmp++; if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.tt !== fn_tt || if0.func_x !== 6'd0) begin
            n_bad++; $display("FAIL parity_hold got done %b busy %b x %0d want 0 0 0 with tt held", if0.done, if0.busy, if0.func_x); end
    endtask

    task automatic test_tied_one();
        int dk;
        fn_tt = {64{1'b1}};
        run_sweep(1'b0, 64'd0, -1, dk);
        n_cmp++; if (dk !== 65) begin n_bad++; $display("FAIL ones_done_cycle got %0d want 65", dk); end
        n_cmp++; if (if0.mismatch_cnt !== 7'd64 || if0.first_bad !== 6'd0 || if0.any_bad !== 1'b1) begin
            n_bad++; $display("FAIL ones_results got %0d/%0d/%b want 64/0/1", if0.mismatch_cnt, if0.first_bad, if0.any_bad); end
        n_cmp++; if (if0.tt !== {64{1'b1}}) begin n_bad++; $display("FAIL ones_tt got %h want all ones", if0.tt); end
        @(negedge clk);
    endtask

    task automatic test_flip();
        int dk;
        logic [63:0] e;
        fn_tt = parity_tt();
        e = 64'h6996_9669_9669_6996 ^ (64'd1 << 37) ^ (64'd1 << 50);
        run_sweep(1'b0, e, -1, dk);
        n_cmp++; if (if0.mismatch_cnt !== 7'd2 || if0.first_bad !== 6'd37 || if0.any_bad !== 1'b1) begin
            n_bad++; $display("FAIL flip_results got %0d/%0d/%b want 2/37/1", if0.mismatch_cnt, if0.first_bad, if0.any_bad); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int dk;
        logic [63:0] m, e;
        for (int it = 0; it < 6; it++) begin
            fn_tt = {$urandom, $urandom};
            m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (it == 0) m = 64'd0;
            if (it == 1) m = 64'h8000_0000_0000_0000;
            e = fn_tt ^ m;
            run_sweep(1'b0, e, -1, dk);
            n_cmp++; if (dk !== 65 || if0.tt !== fn_tt) begin
                n_bad++; $display("FAIL rand%0d_tt done %0d tt %h want 65 %h", it, dk, if0.tt, fn_tt); end
            n_cmp++; if (int'(if0.mismatch_cnt) != popc(m) || int'(if0.first_bad) != lowest(m) || if0.any_bad !== (m != 64'd0)) begin
                n_bad++; $display("FAIL rand%0d_results got %0d/%0d/%b want %0d/%0d/%b", it, if0.mismatch_cnt,
                                  if0.first_bad, if0.any_bad, popc(m), lowest(m), (m != 64'd0)); end
            @(negedge clk);
        end
    endtask

    task automatic test_lat2();
        int dk, errs;
        logic [63:0] m;
        fn_tt = parity_tt();
        run_sweep(1'b1, 64'h6996_9669_9669_6996, -1, dk);
        n_cmp++; if (dk !== 193) begin n_bad++; $display("FAIL lat2_done_cycle got %0d want 193", dk); end
        n_cmp++; if (if2.mismatch_cnt !== 7'd0 || if2.tt !== fn_tt) begin
            n_bad++; $display("FAIL lat2_results got %0d %h want 0 %h", if2.mismatch_cnt, if2.tt, fn_tt); end
        errs = 0;
        for (int i = 0; i < xcount; i++) if (xlog[i] !== 6'(i / 3)) errs++;
        n_cmp++; if (errs != 0 || xcount != 192 || overlap != 0) begin
            n_bad++; $display("FAIL lat2_func_x_hold got %0d bad of %0d want 0 of 192", errs, xcount); end
        @(negedge clk);
        fn_tt = {$urandom, $urandom};
        m = {$urandom, $urandom} & {$urandom, $urandom};
        run_sweep(1'b1, fn_tt ^ m, -1, dk);
        n_cmp++; if (int'(if2.mismatch_cnt) != popc(m) || int'(if2.first_bad) != lowest(m) || if2.tt !== fn_tt) begin
            n_bad++; $display("FAIL lat2_rand got %0d/%0d want %0d/%0d", if2.mismatch_cnt, if2.first_bad, popc(m), lowest(m)); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int dk, extra;
        fn_tt = parity_tt();
        run_sweep(1'b0, 64'h6996_9669_9669_6996, 11, dk);
        n_cmp++; if (dk !== 65 || if0.mismatch_cnt !== 7'd0) begin
            n_bad++; $display("FAIL ignore_start got done %0d cnt %0d want 65 0", dk, if0.mismatch_cnt); end
        extra = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (if0.done || if0.busy) extra++;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ignore_start_extra got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int dk, dk2;
        fn_tt = parity_tt();
        run_sweep(1'b0, 64'h6996_9669_9669_6996 ^ (64'd1 << 5), -1, dk);
        n_cmp++; if (dk !== 65 || if0.mismatch_cnt !== 7'd1 || if0.first_bad !== 6'd5) begin
            n_bad++; $display("FAIL b2b_first got %0d/%0d/%0d want 65/1/5", dk, if0.mismatch_cnt, if0.first_bad); end
        if0.start = 1'b1; if0.expect_tt = 64'd0;
        @(negedge clk);
        if0.start = 1'b0;
        fn_tt = {64{1'b1}};
        n_cmp++; if (if0.busy !== 1'b1 || if0.done !== 1'b0 || if0.func_x !== 6'd0) begin
            n_bad++; $display("FAIL b2b_restart got busy %b done %b x %0d want 1 0 0", if0.busy, if0.done, if0.func_x); end
        n_cmp++; if (if0.tt !== 64'd0 || if0.mismatch_cnt !== 7'd0 || if0.any_bad !== 1'b0 || if0.first_bad !== 6'd0) begin
            n_bad++; $display("FAIL b2b_cleared got %h/%0d/%b/%0d want 0/0/0/0", if0.tt, if0.mismatch_cnt, if0.any_bad, if0.first_bad); end
        dk2 = -1;
        for (int k = 1; k <= 100; k++) begin
            if (if0.done) begin dk2 = k; break; end
            @(negedge clk);
        end
        n_cmp++; if (dk2 !== 65 || if0.mismatch_cnt !== 7'd64) begin
            n_bad++; $display("FAIL b2b_second got done %0d cnt %0d want 65 64", dk2, if0.mismatch_cnt); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int seen, act;
        fn_tt = parity_tt();
        if0.start = 1'b1; if0.expect_tt = 64'd0;
        @(negedge clk);
        if0.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (if0.func_x == 6'd20) begin seen = 1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL arst_reach_vec20 got %0d want 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if0.func_x !== 6'd0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.tt !== 64'd0 ||
                     if0.mismatch_cnt !== 7'd0 || if0.first_bad !== 6'd0 || if0.any_bad !== 1'b0) begin
            n_bad++; $display("FAIL arst_outputs got x %0d busy %b tt %h cnt %0d want all 0", if0.func_x, if0.busy, if0.tt, if0.mismatch_cnt); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (if0.busy || if0.done) act++;
        end
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL arst_quiet got %0d active cycles want 0", act); end
    endtask

    initial begin
        if0.start = 1'b0; if0.expect_tt = 64'd0;
        if2.start = 1'b0; if2.expect_tt = 64'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_parity();
        test_tied_one();
        test_flip();
        test_random();
        test_lat2();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
